// File: rtl/handshake_constant_check.sv
// Sink-side checker: compares each accepted token against CONST_VALUE and emits a registered
// match bit on a one-entry elastic output. Optional statistics under HANDSHAKE_CONSTANT_CHECK_STATS_EN.
module handshake_constant_check #(
    parameter int              DATA_WIDTH  = 32,
    parameter logic [11:0]     CONST_VALUE = 12'b111111011001,
    parameter int              CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] err_value
);

    localparam logic [DATA_WIDTH-1:0] CONST_EXT = DATA_WIDTH'(CONST_VALUE);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   outs_q;
    logic   outs_d;
    logic   accept_s;
    logic   match_s;

    // Input handshake: ready depends only on buffer state and downstream ready.
    always_comb begin
        ins_ready = (state_q == ST_EMPTY) || outs_ready;
        accept_s  = ins_valid && ins_ready;
        match_s   = (ins == CONST_EXT);
    end

    // Next-state and result-load logic for the one-entry output buffer.
    always_comb begin
        state_d = state_q;
        outs_d  = outs_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                    outs_d  = match_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (outs_ready && accept_s) begin
                    outs_d = match_s;
                end else if (outs_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                outs_d  = 1'b0;
            end
        endcase
    end

    // Buffer state and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            outs_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
        end
    end

    assign outs       = outs_q;
    assign outs_valid = (state_q == ST_FULL);

`ifdef HANDSHAKE_CONSTANT_CHECK_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]  match_cnt_q;
    logic [CNT_WIDTH-1:0]  match_cnt_d;
    logic [CNT_WIDTH-1:0]  mismatch_cnt_q;
    logic [CNT_WIDTH-1:0]  mismatch_cnt_d;
    logic                  err_q;
    logic                  err_d;
    logic [DATA_WIDTH-1:0] err_value_q;
    logic [DATA_WIDTH-1:0] err_value_d;

    // Saturating counters and first-mismatch capture, advanced only on accept.
    always_comb begin
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        err_d          = err_q;
        err_value_d    = err_value_q;
        if (accept_s && match_s) begin
            if (match_cnt_q != CNT_MAX) begin
                match_cnt_d = match_cnt_q + CNT_ONE;
            end else begin
                match_cnt_d = match_cnt_q;
            end
        end else if (accept_s) begin
            if (mismatch_cnt_q != CNT_MAX) begin
                mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
            end else begin
                mismatch_cnt_d = mismatch_cnt_q;
            end
            if (!err_q) begin
                err_d       = 1'b1;
                err_value_d = ins;
            end else begin
                err_d       = err_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q    <= {CNT_WIDTH{1'b0}};
            mismatch_cnt_q <= {CNT_WIDTH{1'b0}};
            err_q          <= 1'b0;
            err_value_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            err_q          <= err_d;
            err_value_q    <= err_value_d;
        end
    end

    assign match_cnt    = match_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign err          = err_q;
    assign err_value    = err_value_q;
`else
    assign match_cnt    = {CNT_WIDTH{1'b0}};
    assign mismatch_cnt = {CNT_WIDTH{1'b0}};
    assign err          = 1'b0;
    assign err_value    = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: doc/handshake_constant_check.md
# handshake_constant_check

Receiving-end counterpart of the dataflow constant source. It consumes a valid/ready data channel, compares every accepted token against a compile-time constant, and emits a registered 1-bit match token on an elastic output channel. With statistics enabled it also keeps saturating match/mismatch counters and captures the first mismatching value. It sits at the sink side of constant-producing channels in the generated dataflow HDL, as a checker or as an `eq-const` operator.

## Interface
- `DATA_WIDTH`, 32, width of the `ins` data channel.
- `CONST_VALUE`, 12'b111111011001 (0xFD9), expected value, zero-extended or truncated to `DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the statistics counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ins`  in  DATA_WIDTH  input data.
- `ins_valid`  in  1  input token present.
- `ins_ready`  out  1  input token accepted when high with `ins_valid`.
- `outs`  out  1  registered compare result, 1 = `ins` equalled `CONST_VALUE`.
- `outs_valid`  out  1  output token present.
- `outs_ready`  in  1  downstream accepts.
- `match_cnt`  out  CNT_WIDTH  saturating count of matching tokens (stats only).
- `mismatch_cnt`  out  CNT_WIDTH  saturating count of mismatching tokens (stats only).
- `err`  out  1  sticky, set on the first mismatch (stats only).
- `err_value`  out  DATA_WIDTH  `ins` value of the first mismatch (stats only).

## Operation
- One-entry output buffer with two states, EMPTY and FULL. `outs_valid` is 1 exactly in FULL.
- `ins_ready = !FULL || outs_ready`. This is a combinational path from `outs_ready`; there is no path from `ins_valid` to `ins_ready`.
- Accept means `ins_valid && ins_ready`. Drain means `outs_valid && outs_ready`.
- State transitions:
  - EMPTY + accept → FULL, loading `outs`.
  - FULL + drain, no accept → EMPTY.
  - FULL + drain + accept in the same cycle → stay FULL and reload `outs`.
  - FULL, no drain → hold. `outs` stays stable and no accept happens.
- Compare is a full-width equality of `ins` against `CONST_VALUE` resized to `DATA_WIDTH`. If `DATA_WIDTH` < 12, only the low `DATA_WIDTH` bits of the constant are used.
- Statistics update only on accept, counting every accepted token:
  - On a match, `match_cnt` increments.
  - On a mismatch, `mismatch_cnt` increments.
  - Each counter saturates at all-ones and never wraps.
- On the first mismatch while `err` = 0: set `err` and capture `err_value`. Later mismatches do not overwrite them. Only `rst` clears them.
- `outs` and the counters are always driven; `outs` is a don't-care while `outs_valid` = 0 but is held at its last value.

## Timing
- Latency is one cycle: a token accepted in cycle N appears on `outs` with `outs_valid` = 1 in cycle N+1.
- Throughput is one token per cycle when `outs_ready` is held high.
- Reset values: state EMPTY, `outs_valid` = 0, `outs` = 0, `ins_ready` = 1, `match_cnt` = 0, `mismatch_cnt` = 0, `err` = 0, `err_value` = 0.
- Reset mid-operation: a buffered token is dropped and not counted. The cycle with `rst` high accepts nothing even though `ins_ready` reads 1.
- Output-channel rule: once `outs_valid` rises, `outs_valid` and `outs` hold until a drain occurs.
- Counter saturation: at all-ones, a further accept leaves the counter unchanged. The token is still passed through.

## Configuration
- Macro `HANDSHAKE_CONSTANT_CHECK_STATS_EN`.
- Defined: the counters, `err` and `err_value` are implemented as described.
- Undefined: no counter or capture registers are instantiated. `match_cnt`, `mismatch_cnt`, `err` and `err_value` are tied to 0. The handshake and `outs` behave identically in both builds.

## Test plan
- Reset and single token: assert `rst` for 2 cycles. Check `outs_valid`=0, `ins_ready`=1 and all stats 0. Then send `ins`=0xFD9 with `outs_ready`=1 → next cycle `outs`=1, `outs_valid`=1, `match_cnt`=1.
- Streaming mismatch capture: send back-to-back 0xFD9, 0x0001, 0x0002, 0xFD9 with `outs_ready`=1 → `outs` sequence 1,0,0,1 on consecutive cycles. Final `match_cnt`=2, `mismatch_cnt`=2, `err`=1, `err_value`=0x0001.
- Backpressure: hold `outs_ready`=0 after one accepted token → `ins_ready`=0, `outs` stable, no further count changes. Release → simultaneous drain and accept, `outs_valid` stays 1.
- Saturation: with `CNT_WIDTH`=4, send 20 matching tokens → `match_cnt`=15 and all 20 tokens are emitted.
- Reset mid-stream: assert `rst` while FULL with `outs_ready`=0 → next cycle `outs_valid`=0, counters 0, `err`=0.
- Stats compiled out: rerun the streaming scenario without the macro → identical `outs` sequence, all stats ports 0.
